// File: rtl/taillight_seq.sv
// rtl/taillight_seq.sv - parametrised left/right taillight sweep sequencer with hazard lockstep
// Optional brake overlay on idle banks: define TAILLIGHT_BRAKE_EN.
module taillight_seq #(
  parameter int LEDS_PER_SIDE = 3,
  parameter int STEP_CYCLES   = 8750000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     left_req,
  input  logic                     right_req,
  input  logic                     hazard_req,
`ifdef TAILLIGHT_BRAKE_EN
  input  logic                     brake_req,
`endif
  output logic [LEDS_PER_SIDE-1:0] led_left,
  output logic [LEDS_PER_SIDE-1:0] led_right,
  output logic                     step_tick
);

  localparam int CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam int PW = $clog2(LEDS_PER_SIDE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0] P_MAX    = PW'(LEDS_PER_SIDE);

  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     tick_q, tick_d;
  logic [PW-1:0]            pl_q, pl_d, pr_q, pr_d;
  logic                     haz_prev_q, haz_prev_d;
  logic [LEDS_PER_SIDE-1:0] led_left_q, led_left_d, led_right_q, led_right_d;
  logic                     eff_l, eff_r;

  // One sweep step: N wraps to 0 (the dark step), a low request aborts to 0.
  function automatic logic [PW-1:0] advance(input logic [PW-1:0] p, input logic req);
    if (!req) return '0;
    return (p == P_MAX) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [LEDS_PER_SIDE-1:0] map_left(input logic [PW-1:0] p);
    logic [LEDS_PER_SIDE-1:0] m;
    for (int i = 0; i < LEDS_PER_SIDE; i++) m[i] = (i < int'(p));
    return m;
  endfunction

  function automatic logic [LEDS_PER_SIDE-1:0] map_right(input logic [PW-1:0] p);
    logic [LEDS_PER_SIDE-1:0] m;
    for (int i = 0; i < LEDS_PER_SIDE; i++) m[i] = (i >= LEDS_PER_SIDE - int'(p));
    return m;
  endfunction

  always_comb begin
    cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    tick_d     = (cnt_d == CNT_LAST);
    eff_l      = left_req | hazard_req;
    eff_r      = right_req | hazard_req;
    pl_d       = pl_q;
    pr_d       = pr_q;
    haz_prev_d = haz_prev_q;
    if (tick_q) begin
      haz_prev_d = hazard_req;
      // Hazard onset re-aligns both banks; afterwards identical inputs keep them locked.
      if (hazard_req && !haz_prev_q) begin
        pl_d = PW'(1);
        pr_d = PW'(1);
      end else begin
        pl_d = advance(pl_q, eff_l);
        pr_d = advance(pr_q, eff_r);
      end
    end
    led_left_d  = map_left(pl_d);
    led_right_d = map_right(pr_d);
`ifdef TAILLIGHT_BRAKE_EN
    if (brake_req && !eff_l) led_left_d  = '1;
    if (brake_req && !eff_r) led_right_d = '1;
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      pl_q        <= '0;
      pr_q        <= '0;
      haz_prev_q  <= 1'b0;
      led_left_q  <= '0;
      led_right_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      pl_q        <= pl_d;
      pr_q        <= pr_d;
      haz_prev_q  <= haz_prev_d;
      led_left_q  <= led_left_d;
      led_right_q <= led_right_d;
    end
  end

  assign led_left  = led_left_q;
  assign led_right = led_right_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_taillight_seq.sv
// tb/tb_taillight_seq.sv - randomized and directed bench for taillight_seq (N=3 and N=4 instances)
// Brake paths are exercised when TAILLIGHT_BRAKE_EN is defined.
module tb_taillight_seq;

  localparam int STEP = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0, left_req = 1'b0, right_req = 1'b0, hazard_req = 1'b0, brake_req = 1'b0;
  logic [2:0] led_left3, led_right3;
  logic [3:0] led_left4, led_right4;
  logic       tick3, tick4;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, index 0 is the N=3 instance, index 1 the N=4 instance.
  bit m_valid = 1'b0;
  int m_since;
  bit m_hprev;
  bit m_tick;
  int m_pl[2], m_pr[2], m_ll[2], m_lr[2];

  taillight_seq #(.LEDS_PER_SIDE(3), .STEP_CYCLES(STEP)) u_dut3 (
    .CLOCK_50(clk), .reset(reset), .left_req(left_req), .right_req(right_req),
    .hazard_req(hazard_req),
`ifdef TAILLIGHT_BRAKE_EN
    .brake_req(brake_req),
`endif
    .led_left(led_left3), .led_right(led_right3), .step_tick(tick3));

  taillight_seq #(.LEDS_PER_SIDE(4), .STEP_CYCLES(STEP)) u_dut4 (
    .CLOCK_50(clk), .reset(reset), .left_req(left_req), .right_req(right_req),
    .hazard_req(hazard_req),
`ifdef TAILLIGHT_BRAKE_EN
    .brake_req(brake_req),
`endif
    .led_left(led_left4), .led_right(led_right4), .step_tick(tick4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int next_phase(input int p, input bit req, input int n);
    return req ? (p + 1) % (n + 1) : 0;
  endfunction

  task automatic model_edge();
    int  nn;
    bit  brk;
    brk = 1'b0;
`ifdef TAILLIGHT_BRAKE_EN
    brk = brake_req;
`endif
    if (reset) begin
      m_valid = 1'b1; m_since = 0; m_hprev = 1'b0; m_tick = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_pl[k] = 0; m_pr[k] = 0; m_ll[k] = 0; m_lr[k] = 0;
      end
      return;
    end
    if (!m_valid) return;
    if (m_since % STEP == STEP - 1) begin
      for (int k = 0; k < 2; k++) begin
        nn = k ? 4 : 3;
        if (hazard_req && !m_hprev) begin
          m_pl[k] = 1; m_pr[k] = 1;
        end else begin
          m_pl[k] = next_phase(m_pl[k], left_req | hazard_req, nn);
          m_pr[k] = next_phase(m_pr[k], right_req | hazard_req, nn);
        end
      end
      m_hprev = hazard_req;
    end
    m_since++;
    m_tick = (m_since % STEP == STEP - 1);
    for (int k = 0; k < 2; k++) begin
      nn = k ? 4 : 3;
      m_ll[k] = (1 << m_pl[k]) - 1;
      m_lr[k] = ((1 << nn) - 1) ^ ((1 << (nn - m_pr[k])) - 1);
      if (brk && !(left_req | hazard_req))  m_ll[k] = (1 << nn) - 1;
      if (brk && !(right_req | hazard_req)) m_lr[k] = (1 << nn) - 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (m_valid) begin
      check("tick3", tick3, m_tick);
      check("tick4", tick4, m_tick);
      check("led_left3", led_left3, m_ll[0]);
      check("led_right3", led_right3, m_lr[0]);
      check("led_left4", led_left4, m_ll[1]);
      check("led_right4", led_right4, m_lr[1]);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] exp3_l[8];
    logic [3:0] exp4_l[8];
    logic [2:0] exp3_r[5];
    logic [2:0] haz_l[4], haz_r[4];
    logic [2:0] prev3;
    int         act;
    exp3_l = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001, 3'b011, 3'b111, 3'b000};
    exp4_l = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001, 4'b0011, 4'b0111};
    exp3_r = '{3'b100, 3'b110, 3'b111, 3'b000, 3'b100};
    haz_l  = '{3'b011, 3'b111, 3'b000, 3'b001};
    haz_r  = '{3'b110, 3'b111, 3'b000, 3'b100};

    // Reset in the middle of a sweep, then first tick timing and left sweep.
    left_req = 1'b1;
    do_reset();
    cycles(15);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_led_left", led_left3, 3'b000);
    check("rst_led_right", led_right3, 3'b000);
    check("rst_tick", tick3, 1'b0);
    cycles(8);
    check("tick_before_first", tick3, 1'b0);
    cycle();
    check("first_tick", tick3, 1'b1);
    prev3 = 3'b000;
    act   = 0;
    cycle();
    for (int s = 0; s < 8; s++) begin
      if (s > 0) cycles(STEP);
      check("left_sweep3", led_left3, exp3_l[s]);
      check("left_sweep4", led_left4, exp4_l[s]);
      check("left_sweep_right_dark", led_right3, 3'b000);
      if (prev3 == 3'b000 && led_left3 != 3'b000) act++;
      prev3 = led_left3;
    end
    check("left_activations", act, 2);

    // Right sweep.
    left_req = 1'b0; right_req = 1'b1;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      cycles(STEP);
      check("right_sweep3", led_right3, exp3_r[s]);
      check("right_sweep_left_dark", led_left3, 3'b000);
    end

    // Hazard onset while left is mid-sweep forces both banks to phase 1 together.
    left_req = 1'b1; right_req = 1'b0;
    do_reset();
    cycles(2 * STEP);
    check("pre_haz_left", led_left3, 3'b011);
    hazard_req = 1'b1;
    cycles(STEP - 1);
    check("haz_right_waits", led_right3, 3'b000);
    cycle();
    check("haz_onset_left", led_left3, 3'b001);
    check("haz_onset_right", led_right3, 3'b100);
    for (int s = 0; s < 4; s++) begin
      cycles(STEP);
      check("haz_lock_left", led_left3, haz_l[s]);
      check("haz_lock_right", led_right3, haz_r[s]);
    end
    hazard_req = 1'b0;
    cycles(STEP);
    check("haz_release_left", led_left3, 3'b011);
    check("haz_release_right", led_right3, 3'b000);

    // Abort mid-sweep, then a short request pulse between ticks.
    hazard_req = 1'b0; left_req = 1'b1;
    do_reset();
    cycles(2 * STEP);
    left_req = 1'b0;
    cycles(STEP - 1);
    check("abort_hold", led_left3, 3'b011);
    cycle();
    check("abort_dark", led_left3, 3'b000);
    cycles(2);
    left_req = 1'b1;
    cycles(3);
    left_req = 1'b0;
    cycles(5);
    check("pulse_invisible", led_left3, 3'b000);

`ifdef TAILLIGHT_BRAKE_EN
    right_req = 1'b1;
    do_reset();
    cycles(15);
    brake_req = 1'b1;
    cycle();
    check("brake_left3", led_left3, 3'b111);
    check("brake_left4", led_left4, 4'b1111);
    cycles(12);
    hazard_req = 1'b1;
    cycle();
    check("brake_haz_override", led_left3, 3'b000);
    cycles(2 * STEP);
    brake_req = 1'b0; hazard_req = 1'b0; right_req = 1'b0;
`endif

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) left_req   = ~left_req;
      if ($urandom_range(0, 15) == 0) right_req  = ~right_req;
      if ($urandom_range(0, 23) == 0) hazard_req = ~hazard_req;
      if ($urandom_range(0, 11) == 0) brake_req  = ~brake_req;
      reset = ($urandom_range(0, 399) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
